huffman_decoder: RTL and testbench

- Downstream stage of the Huffman packing coder.
- Consumes the packed 32-bit words produced by that coder and unpacks them back into fixed-width symbols.
- Code bits are LSB-first: the first code in a word occupies bit 0 upward, and code bit 0 is the first stream bit.
- A host-loaded table of up to TABLE_SIZE prefix-free codes is matched in parallel; one symbol is decoded per cycle.

---
 rtl/huffman_decoder.sv | 111 +++++++++++
 tb/tb_huffman_decoder.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/huffman_decoder.sv
// huffman_decoder: unpacks LSB-first packed 32-bit words into symbols using a host-loaded prefix-free code table
// Ports:
//   clock, resetn          - rising-edge clock, synchronous active-low reset
//   tbl_we/addr/code/len/sym - code table write (len 0 = entry invalid, 1..8 = code length)
//   in_word/in_valid/in_ready  - packed word input handshake
//   sym_out/sym_valid/sym_ready - decoded symbol output handshake
//   err                    - sticky decode error (no code matches 8+ buffered bits)
//   sym_count, word_count  - decode/accept counters, present only with HUFF_DEC_STATS_EN
module huffman_decoder #(
  parameter int TABLE_SIZE = 16,
  parameter int SYM_W = 8
) (
  input  logic                          clock,
  input  logic                          resetn,
  input  logic                          tbl_we,
  input  logic [$clog2(TABLE_SIZE)-1:0] tbl_addr,
  input  logic [7:0]                    tbl_code,
  input  logic [3:0]                    tbl_len,
  input  logic [SYM_W-1:0]              tbl_sym,
  input  logic [31:0]                   in_word,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic [SYM_W-1:0]              sym_out,
  output logic                          sym_valid,
  input  logic                          sym_ready,
`ifdef HUFF_DEC_STATS_EN
  output logic [31:0]                   sym_count,
  output logic [31:0]                   word_count,
`endif
  output logic                          err
);
  logic [3:0]       len_q  [TABLE_SIZE];
  logic [7:0]       code_q [TABLE_SIZE];
  logic [SYM_W-1:0] tsym_q [TABLE_SIZE];
  logic [39:0]      buf_q, buf_d;
  logic [5:0]       fill_q, fill_d;
  logic [SYM_W-1:0] sym_q, sym_d;
  logic             valid_q, valid_d;
  logic             err_q, err_d;
  logic             hit, dec, acc;
  logic [3:0]       win_len;
  logic [SYM_W-1:0] win_sym;
  logic [5:0]       cons, rem;
  // Descending scan so the lowest matching index is the last to assign and wins.
  always_comb begin
    hit = 1'b0;
    win_len = '0;
    win_sym = '0;
    for (int i = TABLE_SIZE - 1; i >= 0; i--)
      if (len_q[i] != 4'd0 && {2'b0, len_q[i]} <= fill_q &&
          ((buf_q[7:0] ^ code_q[i]) & ~(8'hFF << len_q[i])) == 8'h00) begin
        hit = 1'b1;
        win_len = len_q[i];
        win_sym = tsym_q[i];
      end
  end
  assign in_ready = resetn & (fill_q <= 6'd8) & ~err_q;
  assign acc      = in_valid & in_ready;
  assign dec      = hit & ~err_q & ~tbl_we & (~valid_q | sym_ready);
  assign cons     = dec ? {2'b0, win_len} : 6'd0;
  assign rem      = fill_q - cons;
  // A word can only be accepted with fill <= 8, so it always lands inside the 40-bit buffer.
  always_comb begin
    buf_d   = (buf_q >> cons) | (acc ? ({8'b0, in_word} << rem) : 40'b0);
    fill_d  = rem + (acc ? 6'd32 : 6'd0);
    sym_d   = dec ? win_sym : sym_q;
    valid_d = dec ? 1'b1 : (sym_ready ? 1'b0 : valid_q);
    err_d   = err_q | (~hit & (fill_q >= 6'd8));
  end
  always_ff @(posedge clock)
    if (!resetn) begin
      buf_q   <= '0;
      fill_q  <= '0;
      sym_q   <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      buf_q   <= buf_d;
      fill_q  <= fill_d;
      sym_q   <= sym_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  always_ff @(posedge clock)
    if (!resetn)
      for (int i = 0; i < TABLE_SIZE; i++) len_q[i] <= 4'd0;
    else if (tbl_we && int'(tbl_addr) < TABLE_SIZE)
      len_q[tbl_addr] <= tbl_len;
  always_ff @(posedge clock)
    if (resetn && tbl_we && int'(tbl_addr) < TABLE_SIZE) begin
      code_q[tbl_addr] <= tbl_code;
      tsym_q[tbl_addr] <= tbl_sym;
    end
  assign sym_out   = sym_q;
  assign sym_valid = valid_q;
  assign err       = err_q;
`ifdef HUFF_DEC_STATS_EN
  logic [31:0] scnt_q, wcnt_q;
  always_ff @(posedge clock)
    if (!resetn) begin
      scnt_q <= '0;
      wcnt_q <= '0;
    end else begin
      scnt_q <= scnt_q + (dec ? 32'd1 : 32'd0);
      wcnt_q <= wcnt_q + (acc ? 32'd1 : 32'd0);
    end
  assign sym_count  = scnt_q;
  assign word_count = wcnt_q;
`else
`endif
endmodule

// File: tb/tb_huffman_decoder.sv
// tb_huffman_decoder: directed scoreboard bench for huffman_decoder
module tb_huffman_decoder;
  logic        clock = 1'b0, resetn = 1'b0, tbl_we = 1'b0;
  logic [3:0]  tbl_addr = '0, tbl_len = '0;
  logic [7:0]  tbl_code = '0, tbl_sym = '0;
  logic [31:0] in_word = '0;
  logic        in_valid = 1'b0, sym_ready = 1'b1;
  logic        in_ready, sym_valid, err;
  logic [7:0]  sym_out;
`ifdef HUFF_DEC_STATS_EN
  logic [31:0] sym_count, word_count;
`endif
  int checks = 0, failures = 0, cyc = 0, pops = 0, first_pop = 0, last_pop = 0;
  logic [7:0] q[$];

  huffman_decoder dut (
    .clock(clock), .resetn(resetn), .tbl_we(tbl_we), .tbl_addr(tbl_addr),
    .tbl_code(tbl_code), .tbl_len(tbl_len), .tbl_sym(tbl_sym),
    .in_word(in_word), .in_valid(in_valid), .in_ready(in_ready),
    .sym_out(sym_out), .sym_valid(sym_valid), .sym_ready(sym_ready),
`ifdef HUFF_DEC_STATS_EN
    .sym_count(sym_count), .word_count(word_count),
`endif
    .err(err)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  always @(negedge clock)
    if (resetn && sym_valid && sym_ready) begin
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_sym actual=%0h required=none", sym_out);
      end else begin
        check("sym", {24'b0, sym_out}, {24'b0, q.pop_front()});
        if (pops == 0) first_pop = cyc;
        last_pop = cyc;
        pops++;
      end
    end

  task automatic step(input int n = 1);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    in_valid = 1'b0;
    tbl_we = 1'b0;
    q.delete();
    #1 check("rst_in_ready", {31'b0, in_ready}, 32'd0);
    step();
    resetn = 1'b1;
    pops = 0;
    check("rst_sym_valid", {31'b0, sym_valid}, 32'd0);
    check("rst_err", {31'b0, err}, 32'd0);
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] c, input logic [3:0] l, input logic [7:0] s);
    tbl_addr = a; tbl_code = c; tbl_len = l; tbl_sym = s; tbl_we = 1'b1;
    step();
    tbl_we = 1'b0;
  endtask

  task automatic send(input logic [31:0] w);
    bit done = 0;
    in_word = w;
    in_valid = 1'b1;
    for (int k = 0; k < 100 && !done; k++) begin
      @(negedge clock);
      if (in_ready) begin
        @(posedge clock);
        #1;
        done = 1;
      end
    end
    in_valid = 1'b0;
    if (!done) check("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_q(input int n);
    for (int k = 0; k < 300 && q.size() > n; k++) step();
    check("wait_q", q.size(), n);
  endtask

  task automatic push_basic();
    q.push_back(8'h41); q.push_back(8'h42); q.push_back(8'h43);
    repeat (27) q.push_back(8'h41);
  endtask

  task automatic load_basic();
    wr(4'd0, 8'h00, 4'd1, 8'h41);
    wr(4'd1, 8'h01, 4'd2, 8'h42);
    wr(4'd2, 8'h03, 4'd2, 8'h43);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    step(2);
    // basic decode
    do_reset();
    load_basic();
    push_basic();
    send(32'h0000001A);
    wait_q(0);
    step(3);
    check("basic_count", pops, 30);
    check("basic_consecutive", last_pop - first_pop, 29);
    check("basic_err", {31'b0, err}, 32'd0);
    check("basic_in_ready", {31'b0, in_ready}, 32'd1);
    // word-straddling code
    do_reset();
    wr(4'd0, 8'h00, 4'd1, 8'h41);
    wr(4'd3, 8'hA5, 4'd8, 8'h5A);
    repeat (28) q.push_back(8'h41);
    q.push_back(8'h5A);
    repeat (28) q.push_back(8'h41);
    send(32'h50000000);
    wait_q(29);
    step(3);
    check("stall_err", {31'b0, err}, 32'd0);
    check("stall_sym_valid", {31'b0, sym_valid}, 32'd0);
    check("stall_in_ready", {31'b0, in_ready}, 32'd1);
    send(32'h0000000A);
    wait_q(0);
    step(3);
    check("straddle_count", pops, 57);
`ifdef HUFF_DEC_STATS_EN
    check("word_count", word_count, 32'd2);
    check("sym_count", sym_count, 32'd57);
`endif
    // error
    do_reset();
    wr(4'd2, 8'h03, 4'd2, 8'h43);
    send(32'h00000000);
    step();
    check("err_set", {31'b0, err}, 32'd1);
    check("err_sym_valid", {31'b0, sym_valid}, 32'd0);
    check("err_in_ready", {31'b0, in_ready}, 32'd0);
    step(5);
    check("err_sticky", {31'b0, err}, 32'd1);
    check("err_in_ready_hold", {31'b0, in_ready}, 32'd0);
    // backpressure
    do_reset();
    load_basic();
    sym_ready = 1'b0;
    push_basic();
    send(32'h0000001A);
    for (int k = 0; k < 20 && !sym_valid; k++) step();
    for (int k = 0; k < 5; k++) begin
      check("bp_valid", {31'b0, sym_valid}, 32'd1);
      check("bp_sym", {24'b0, sym_out}, 32'h41);
      step();
    end
    sym_ready = 1'b1;
    wait_q(0);
    step(3);
    check("bp_count", pops, 30);
    // reset mid-stream
    do_reset();
    load_basic();
    push_basic();
    send(32'h0000001A);
    wait_q(20);
    check("mid_pops", pops, 10);
    do_reset();
    send(32'h0000001A);
    step();
    check("tbl_invalid_err", {31'b0, err}, 32'd1);
    check("tbl_invalid_valid", {31'b0, sym_valid}, 32'd0);
    do_reset();
    load_basic();
    push_basic();
    send(32'h0000001A);
    wait_q(0);
    step(3);
    check("rerun_count", pops, 30);
    check("rerun_err", {31'b0, err}, 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
